// File: rtl/nios_security_pwm_gen.sv
// Servo/ESC PWM generator with arm/failsafe control and per-frame slew limiting.
//
// A free-running frame counter defines PWM frames of PERIOD cycles. All control
// inputs (duty_in, enable) are sampled only at the last cycle of a frame, so a
// pulse already in progress is never cut short or stretched.
//
// Ports:
//   clk        in   single clock
//   reset_n    in   asynchronous active-low reset
//   duty_in    in   [31:0] requested high time in cycles
//   enable     in   arm request
//   pwm_out    out  registered PWM output
//   frame_tick out  high for the last cycle of each frame
//   width_out  out  [31:0] currently applied high time
//   clamped    out  last sampled nonzero duty_in was clamped into range
//   state      out  [1:0] 00 DISABLED, 01 RUN, 10 FAILSAFE
module nios_security_pwm_gen #(
    parameter int unsigned PERIOD    = 1000000,
    parameter int unsigned MIN_PULSE = 50000,
    parameter int unsigned MAX_PULSE = 100000,
    parameter int unsigned NEUTRAL   = 75000,
    parameter int unsigned SLEW      = 500
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] duty_in,
    input  logic        enable,
    output logic        pwm_out,
    output logic        frame_tick,
    output logic [31:0] width_out,
    output logic        clamped,
    output logic [1:0]  state
);

    localparam logic [31:0] CntLast  = 32'(PERIOD - 1);
    localparam logic [31:0] MinW     = 32'(MIN_PULSE);
    localparam logic [31:0] MaxW     = 32'(MAX_PULSE);
    localparam logic [31:0] NeutralW = 32'(NEUTRAL);
    localparam logic [31:0] SlewW    = 32'(SLEW);

    typedef enum logic [1:0] {
        StDisabled = 2'b00,
        StRun      = 2'b01,
        StFailsafe = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] width_q, width_d;
    logic        clamped_q, clamped_d;
    logic        pwm_q, pwm_d;

    logic        frame_end;
    logic        out_of_range;
    logic [31:0] duty_target;
    logic [31:0] slew_tgt;
    logic [31:0] slewed;

    assign frame_end = (cnt_q == CntLast);

    // Range clamp of the requested duty.
    always_comb begin
        out_of_range = (duty_in < MinW) || (duty_in > MaxW);
        if (duty_in < MinW) begin
            duty_target = MinW;
        end else if (duty_in > MaxW) begin
            duty_target = MaxW;
        end else begin
            duty_target = duty_in;
        end
    end

    // Step width toward slew_tgt by at most SlewW; differences are taken in the
    // direction that cannot underflow, and width+SlewW stays below the target.
    always_comb begin
        slewed = slew_tgt;
        if (slew_tgt >= width_q) begin
            if ((slew_tgt - width_q) > SlewW) begin
                slewed = width_q + SlewW;
            end
        end else begin
            if ((width_q - slew_tgt) > SlewW) begin
                slewed = width_q - SlewW;
            end
        end
    end

    always_comb begin
        cnt_d     = frame_end ? 32'd0 : cnt_q + 32'd1;
        state_d   = state_q;
        width_d   = width_q;
        clamped_d = clamped_q;
        slew_tgt  = NeutralW;

        if (frame_end) begin
            if (!enable) begin
                // Disarm wins over every other transition.
                state_d   = StDisabled;
                width_d   = NeutralW;
                clamped_d = 1'b0;
            end else begin
                case (state_q)
                    StDisabled: begin
                        // First armed frame always starts at neutral.
                        state_d   = StRun;
                        width_d   = NeutralW;
                        clamped_d = 1'b0;
                    end
                    StRun: begin
                        if (duty_in == 32'd0) begin
                            state_d   = StFailsafe;
                            slew_tgt  = NeutralW;
                            clamped_d = 1'b0;
                        end else begin
                            slew_tgt  = duty_target;
                            clamped_d = out_of_range;
                        end
                        width_d = slewed;
                    end
                    StFailsafe: begin
                        if (duty_in != 32'd0) begin
                            state_d   = StRun;
                            slew_tgt  = duty_target;
                            clamped_d = out_of_range;
                        end else begin
                            slew_tgt  = NeutralW;
                            clamped_d = 1'b0;
                        end
                        width_d = slewed;
                    end
                    default: begin
                        state_d   = StDisabled;
                        width_d   = NeutralW;
                        clamped_d = 1'b0;
                    end
                endcase
            end
        end
    end

    // Output reflects the counter value of the previous cycle.
    assign pwm_d = (state_q != StDisabled) && (cnt_q < width_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= 32'd0;
            state_q   <= StDisabled;
            width_q   <= NeutralW;
            clamped_q <= 1'b0;
            pwm_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            width_q   <= width_d;
            clamped_q <= clamped_d;
            pwm_q     <= pwm_d;
        end
    end

    assign pwm_out    = pwm_q;
    assign frame_tick = frame_end;
    assign width_out  = width_q;
    assign clamped    = clamped_q;
    assign state      = state_q;

endmodule

// File: tb/tb_nios_security_pwm_gen.sv
// Directed testbench for nios_security_pwm_gen with a short frame
// (PERIOD=100, MIN=10, MAX=20, NEUTRAL=15, SLEW=2).
module tb_nios_security_pwm_gen;

    localparam int unsigned PERIOD = 100;

    logic        clk;
    logic        reset_n;
    logic [31:0] duty_in;
    logic        enable;
    logic        pwm_out;
    logic        frame_tick;
    logic [31:0] width_out;
    logic        clamped;
    logic [1:0]  state;

    int tests;
    int failed;

    nios_security_pwm_gen #(
        .PERIOD   (100),
        .MIN_PULSE(10),
        .MAX_PULSE(20),
        .NEUTRAL  (15),
        .SLEW     (2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .duty_in   (duty_in),
        .enable    (enable),
        .pwm_out   (pwm_out),
        .frame_tick(frame_tick),
        .width_out (width_out),
        .clamped   (clamped),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts at a negedge with cnt==0; samples one full frame and returns at
    // the negedge with cnt==0 of the next frame (after the frame-end update).
    task automatic count_frame(output int highs);
        highs = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (pwm_out) highs++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        enable  = 1'b0;
        duty_in = 32'd0;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (pwm_out !== 1'b0) begin
            failed++; $display("FAIL reset_pwm got %0b want 0", pwm_out);
        end
        tests++;
        if (frame_tick !== 1'b0) begin
            failed++; $display("FAIL reset_tick got %0b want 0", frame_tick);
        end
        tests++;
        if (state !== 2'b00) begin
            failed++; $display("FAIL reset_state got %0b want 00", state);
        end
        tests++;
        if (width_out !== 32'd15) begin
            failed++; $display("FAIL reset_width got %0d want 15", width_out);
        end
        tests++;
        if (clamped !== 1'b0) begin
            failed++; $display("FAIL reset_clamped got %0b want 0", clamped);
        end
    endtask

    task automatic test_arm;
        int n;
        int highs;
        enable  = 1'b1;
        duty_in = 32'd15;
        reset_n = 1'b1;
        n = 0;
        while (frame_tick !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n !== PERIOD - 1) begin
            failed++; $display("FAIL arm_first_tick got %0d want %0d", n, PERIOD - 1);
        end
        @(negedge clk);
        tests++;
        if (state !== 2'b01) begin
            failed++; $display("FAIL arm_state got %0b want 01", state);
        end
        tests++;
        if (width_out !== 32'd15) begin
            failed++; $display("FAIL arm_width got %0d want 15", width_out);
        end
        for (int f = 0; f < 2; f++) begin
            count_frame(highs);
            tests++;
            if (highs !== 15) begin
                failed++; $display("FAIL arm_pulse[%0d] got %0d want 15", f, highs);
            end
        end
    endtask

    task automatic test_slew;
        int highs;
        int exp_w[3] = '{17, 19, 20};
        int exp_p[3] = '{15, 17, 19};
        duty_in = 32'd20;
        for (int f = 0; f < 3; f++) begin
            count_frame(highs);
            tests++;
            if (highs !== exp_p[f]) begin
                failed++; $display("FAIL slew_pulse[%0d] got %0d want %0d", f, highs, exp_p[f]);
            end
            tests++;
            if (width_out !== 32'(exp_w[f])) begin
                failed++; $display("FAIL slew_width[%0d] got %0d want %0d", f, width_out, exp_w[f]);
            end
        end
        count_frame(highs);
        tests++;
        if (highs !== 20) begin
            failed++; $display("FAIL slew_pulse_final got %0d want 20", highs);
        end
    endtask

    task automatic test_clamp;
        int highs;
        int exp_dn[5] = '{18, 16, 14, 12, 10};
        int exp_up[5] = '{12, 14, 16, 18, 20};
        duty_in = 32'd50;
        count_frame(highs);
        tests++;
        if (clamped !== 1'b1 || width_out !== 32'd20) begin
            failed++; $display("FAIL clamp_high got clamped=%0b width=%0d want 1/20", clamped, width_out);
        end
        duty_in = 32'd3;
        for (int f = 0; f < 5; f++) begin
            count_frame(highs);
            tests++;
            if (clamped !== 1'b1 || width_out !== 32'(exp_dn[f])) begin
                failed++;
                $display("FAIL clamp_low[%0d] got clamped=%0b width=%0d want 1/%0d",
                         f, clamped, width_out, exp_dn[f]);
            end
        end
        duty_in = 32'd20;
        for (int f = 0; f < 5; f++) begin
            count_frame(highs);
            tests++;
            if (clamped !== 1'b0 || width_out !== 32'(exp_up[f])) begin
                failed++;
                $display("FAIL clamp_clear[%0d] got clamped=%0b width=%0d want 0/%0d",
                         f, clamped, width_out, exp_up[f]);
            end
        end
    endtask

    task automatic test_failsafe;
        int highs;
        int exp_w[3] = '{18, 16, 15};
        duty_in = 32'd0;
        for (int f = 0; f < 3; f++) begin
            count_frame(highs);
            tests++;
            if (state !== 2'b10 || width_out !== 32'(exp_w[f])) begin
                failed++;
                $display("FAIL failsafe[%0d] got state=%0b width=%0d want 10/%0d",
                         f, state, width_out, exp_w[f]);
            end
        end
        count_frame(highs);
        tests++;
        if (highs !== 15) begin
            failed++; $display("FAIL failsafe_pulse got %0d want 15", highs);
        end
        duty_in = 32'd12;
        count_frame(highs);
        tests++;
        if (state !== 2'b01 || width_out !== 32'd13) begin
            failed++; $display("FAIL failsafe_exit got state=%0b width=%0d want 01/13", state, width_out);
        end
        duty_in = 32'd15;
        count_frame(highs);
        tests++;
        if (width_out !== 32'd15) begin
            failed++; $display("FAIL failsafe_restore got %0d want 15", width_out);
        end
    endtask

    task automatic test_disable_mid_frame;
        int highs;
        highs = 0;
        for (int i = 0; i < 5; i++) begin
            if (pwm_out) highs++;
            @(negedge clk);
        end
        enable = 1'b0;
        for (int i = 5; i < PERIOD; i++) begin
            if (pwm_out) highs++;
            @(negedge clk);
        end
        tests++;
        if (highs !== 15) begin
            failed++; $display("FAIL disable_pulse got %0d want 15", highs);
        end
        tests++;
        if (state !== 2'b00 || width_out !== 32'd15) begin
            failed++; $display("FAIL disable_state got state=%0b width=%0d want 00/15", state, width_out);
        end
        count_frame(highs);
        tests++;
        if (highs !== 0) begin
            failed++; $display("FAIL disable_idle_pulse got %0d want 0", highs);
        end
    endtask

    task automatic test_reset_mid_pulse;
        int highs;
        enable  = 1'b1;
        duty_in = 32'd15;
        count_frame(highs);
        tests++;
        if (state !== 2'b01) begin
            failed++; $display("FAIL rearm_state got %0b want 01", state);
        end
        for (int i = 0; i < 8; i++) @(negedge clk);
        tests++;
        if (pwm_out !== 1'b1) begin
            failed++; $display("FAIL premid_pwm got %0b want 1", pwm_out);
        end
        reset_n = 1'b0;
        #1;
        tests++;
        if (pwm_out !== 1'b0 || dut.cnt_q !== 32'd0 || state !== 2'b00) begin
            failed++;
            $display("FAIL midreset got pwm=%0b cnt=%0d state=%0b want 0/0/00",
                     pwm_out, dut.cnt_q, state);
        end
        tests++;
        if (width_out !== 32'd15 || frame_tick !== 1'b0) begin
            failed++; $display("FAIL midreset_width got width=%0d tick=%0b want 15/0", width_out, frame_tick);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        tests   = 0;
        failed  = 0;
        reset_n = 1'b0;
        enable  = 1'b0;
        duty_in = 32'd0;
        test_reset();
        test_arm();
        test_slew();
        test_clamp();
        test_failsafe();
        test_disable_mid_frame();
        test_reset_mid_pulse();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
